// File: rtl/alu_issue_arbiter.sv
// Two-requester in-order issue arbiter for a small ALU pipeline.
// A per-register shift-vector scoreboard holds back readers of a destination
// that was written in the last HAZARD_WINDOW cycles; a round-robin pointer
// picks between two simultaneously eligible requesters. Grant, ready and the
// forwarded instruction are combinational in the grant cycle.
module alu_issue_arbiter #(
  parameter int HAZARD_WINDOW = 2,
  parameter int RR_INIT       = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_en,
  input  logic        req0_valid,
  input  logic [7:0]  req0_inst,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [7:0]  req1_inst,
  output logic        req1_ready,
  output logic [7:0]  issue_inst,
  output logic        issue_src,
  output logic [15:0] issue_cnt0,
  output logic [15:0] issue_cnt1,
  output logic [15:0] stall_cnt
);

  // Requesters gathered into small arrays so per-requester logic can be replicated.
  logic [1:0] req_valid;
  logic [7:0] req_inst [2];

  assign req_valid   = {req1_valid, req0_valid};
  assign req_inst[0] = req0_inst;
  assign req_inst[1] = req1_inst;

  // One bit per architectural register r0..r3: a recent writer is still in flight.
  logic [3:0] blocked;

  // Grant and write-back bookkeeping for the cycle.
  logic [1:0] elig;
  logic [1:0] gnt;
  logic       any_gnt;
  logic [7:0] sel_inst;
  logic       wr_en;
  logic [1:0] wr_rd;

  logic        prio_q, prio_d;
  logic [15:0] cnt0_q, cnt0_d;
  logic [15:0] cnt1_q, cnt1_d;
  logic [15:0] stall_q, stall_d;

  // Eligibility: NOPs never wait; other ops wait while either source is blocked.
  // A pending rd does not matter because writeback is in order.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_elig
      logic is_nop;
      logic src_hazard;
      assign is_nop     = (req_inst[gi][7:6] == 2'b00);
      assign src_hazard = blocked[req_inst[gi][5:4]] | blocked[req_inst[gi][3:2]];
      assign elig[gi]   = req_valid[gi] & issue_en & ~rst & (is_nop | ~src_hazard);
    end
  endgenerate

  // Round-robin pick: contention goes to the requester that was not granted last.
  always_comb begin
    gnt = elig;
    if (elig == 2'b11) begin
      gnt = prio_q ? 2'b10 : 2'b01;
    end
  end

  assign any_gnt  = |gnt;
  assign sel_inst = gnt[1] ? req_inst[1] : req_inst[0];
  // Only a granted non-NOP occupies a destination register.
  assign wr_en    = any_gnt & (sel_inst[7:6] != 2'b00);
  assign wr_rd    = sel_inst[1:0];

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  // A granted NOP is forwarded as the canonical all-zero bubble.
  assign issue_inst = wr_en ? sel_inst : 8'h00;
  assign issue_src  = gnt[1];

  // Scoreboard: each register has a HAZARD_WINDOW-long shift vector whose MSB
  // is loaded by an issuing writer; the register is blocked while any bit is set.
  generate
    if (HAZARD_WINDOW > 0) begin : g_sb
      for (genvar gi = 0; gi < 4; gi++) begin : g_reg
        logic [HAZARD_WINDOW-1:0] pend_q, pend_d;

        // Age existing hazard and insert a new one for this register's writer.
        always_comb begin
          pend_d = pend_q >> 1;
          if (wr_en && (wr_rd == 2'(gi))) begin
            pend_d[HAZARD_WINDOW-1] = 1'b1;
          end
        end

        // Scoreboard keeps aging while issue is disabled; reset drops all hazards.
        always_ff @(posedge clk) begin
          if (rst) begin
            pend_q <= '0;
          end else begin
            pend_q <= pend_d;
          end
        end

        assign blocked[gi] = |pend_q;
      end
    end else begin : g_nosb
      logic unused_wr;
      assign unused_wr = ^{wr_en, wr_rd};
      assign blocked   = 4'b0000;
    end
  endgenerate

  // Next-state for priority pointer and the three statistics counters.
  always_comb begin
    prio_d  = prio_q;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;
    stall_d = stall_q;
    if (any_gnt) begin
      prio_d = ~gnt[1];
    end
    if (gnt[0]) begin
      cnt0_d = cnt0_q + 16'd1;
    end
    if (gnt[1]) begin
      cnt1_d = cnt1_q + 16'd1;
    end
    // With issue enabled, a valid request that is not granted can only be a hazard stall.
    if (issue_en && (|req_valid) && !any_gnt && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  // Register priority and counters; reset restores the initial priority holder.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q  <= (RR_INIT != 0);
      cnt0_q  <= 16'h0000;
      cnt1_q  <= 16'h0000;
      stall_q <= 16'h0000;
    end else begin
      prio_q  <= prio_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
      stall_q <= stall_d;
    end
  end

  assign issue_cnt0 = cnt0_q;
  assign issue_cnt1 = cnt1_q;
  assign stall_cnt  = stall_q;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Self-checking bench for alu_issue_arbiter (HAZARD_WINDOW=2, RR_INIT=0):
// a directed vector table, hand-written multi-cycle sequences, and random
// traffic, all compared against a cycle-count based reference model.
module tb_alu_issue_arbiter;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_en;
  logic        req0_valid, req1_valid;
  logic [7:0]  req0_inst, req1_inst;
  logic        req0_ready, req1_ready;
  logic [7:0]  issue_inst;
  logic        issue_src;
  logic [15:0] issue_cnt0, issue_cnt1, stall_cnt;

  alu_issue_arbiter #(.HAZARD_WINDOW(W), .RR_INIT(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .issue_en   (issue_en),
    .req0_valid (req0_valid),
    .req0_inst  (req0_inst),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_inst  (req1_inst),
    .req1_ready (req1_ready),
    .issue_inst (issue_inst),
    .issue_src  (issue_src),
    .issue_cnt0 (issue_cnt0),
    .issue_cnt1 (issue_cnt1),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: cycle stamp of the last write to each register,
  // the requester that wins a tie, and plain integer counters.
  int cyc = 0;
  int last_wr [4] = '{-1000, -1000, -1000, -1000};
  int prio_m = 0;
  int cnt0_m = 0, cnt1_m = 0, stall_m = 0;

  // Results of the most recent cycle, for directed checks.
  int  last_g;
  bit  s_rdy0, s_rdy1, s_src;
  logic [7:0] s_inst;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic bit m_blk(input logic [1:0] r);
    int age;
    age = cyc - last_wr[r];
    return (W > 0) && (age >= 1) && (age <= W);
  endfunction

  function automatic bit m_elig(input bit r, input bit en, input bit v, input logic [7:0] inst);
    if (!v || !en || r) return 1'b0;
    if (inst[7:6] == 2'b00) return 1'b1;
    return !m_blk(inst[5:4]) && !m_blk(inst[3:2]);
  endfunction

  // One clock: drive inputs, compare combinational outputs mid-cycle,
  // advance the model on the edge, then compare the registered counters.
  task automatic run_cycle(input bit r, input bit en, input bit v0, input logic [7:0] i0,
                           input bit v1, input logic [7:0] i1);
    bit e0, e1;
    int g;
    logic [7:0] sel, exp_inst;
    rst = r; issue_en = en;
    req0_valid = v0; req0_inst = i0;
    req1_valid = v1; req1_inst = i1;
    @(negedge clk);
    e0 = m_elig(r, en, v0, i0);
    e1 = m_elig(r, en, v1, i1);
    if (e0 && e1) g = prio_m;
    else if (e0)  g = 0;
    else if (e1)  g = 1;
    else          g = -1;
    sel = (g == 1) ? i1 : i0;
    exp_inst = (g >= 0 && sel[7:6] != 2'b00) ? sel : 8'h00;
    s_rdy0 = req0_ready; s_rdy1 = req1_ready; s_src = issue_src; s_inst = issue_inst;
    check("ready0", int'(s_rdy0), int'(g == 0));
    check("ready1", int'(s_rdy1), int'(g == 1));
    check("issue_inst", int'(s_inst), int'(exp_inst));
    check("issue_src", int'(s_src), int'(g == 1));
    if (g >= 0) $display("t=%0t grant req%0d inst=%02h issued=%02h", $time, g, sel, s_inst);
    last_g = g;
    @(posedge clk);
    if (r) begin
      for (int k = 0; k < 4; k++) last_wr[k] = -1000;
      prio_m = 0; cnt0_m = 0; cnt1_m = 0; stall_m = 0;
    end else begin
      if (g >= 0) begin
        if (sel[7:6] != 2'b00) last_wr[sel[1:0]] = cyc;
        prio_m = 1 - g;
        if (g == 0) cnt0_m = (cnt0_m + 1) % 65536;
        else        cnt1_m = (cnt1_m + 1) % 65536;
      end else if (en && (v0 || v1) && stall_m < 65535) begin
        stall_m++;
      end
    end
    cyc++;
    #1;
    check("issue_cnt0", int'(issue_cnt0), cnt0_m);
    check("issue_cnt1", int'(issue_cnt1), cnt1_m);
    check("stall_cnt", int'(stall_cnt), stall_m);
  endtask

  task automatic do_reset();
    run_cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  typedef struct {
    bit         en;
    bit         v0;
    logic [7:0] i0;
    bit         v1;
    logic [7:0] i1;
    bit         rdy0;
    bit         rdy1;
    logic [7:0] inst;
    bit         src;
  } vec_t;

  vec_t tbl [8];

  bit hv0, hv1;
  logic [7:0] hi0, hi1;
  bit rr, ren;

  initial begin
    // Directed vectors starting right after reset (priority with requester 0).
    tbl[0] = '{1, 1, 8'h41, 1, 8'h4E, 1, 0, 8'h41, 0};
    tbl[1] = '{1, 1, 8'h41, 1, 8'h4E, 0, 1, 8'h4E, 1};
    tbl[2] = '{1, 1, 8'h41, 1, 8'h4E, 1, 0, 8'h41, 0};
    tbl[3] = '{1, 1, 8'h41, 1, 8'h4E, 0, 1, 8'h4E, 1};
    tbl[4] = '{1, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0};
    tbl[5] = '{0, 1, 8'h41, 1, 8'h4E, 0, 0, 8'h00, 0};
    tbl[6] = '{1, 1, 8'h00, 1, 8'h00, 1, 0, 8'h00, 0};
    tbl[7] = '{1, 0, 8'h00, 1, 8'h03, 0, 1, 8'h00, 1};

    rst = 1'b1; issue_en = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; req0_inst = 8'h00; req1_inst = 8'h00;
    @(posedge clk); #1;
    do_reset();
    do_reset();
    check("reset_cnt0", int'(issue_cnt0), 0);
    check("reset_stall", int'(stall_cnt), 0);

    for (int i = 0; i < 8; i++) begin
      run_cycle(1'b0, tbl[i].en, tbl[i].v0, tbl[i].i0, tbl[i].v1, tbl[i].i1);
      check($sformatf("tbl%0d_rdy0", i), int'(s_rdy0), int'(tbl[i].rdy0));
      check($sformatf("tbl%0d_rdy1", i), int'(s_rdy1), int'(tbl[i].rdy1));
      check($sformatf("tbl%0d_inst", i), int'(s_inst), int'(tbl[i].inst));
      check($sformatf("tbl%0d_src", i), int'(s_src), int'(tbl[i].src));
    end
    check("tbl_cnt0", int'(issue_cnt0), 3);
    check("tbl_cnt1", int'(issue_cnt1), 3);
    check("tbl_stall", int'(stall_cnt), 0);

    // RAW hazard: reader of r1 waits exactly two cycles.
    do_reset();
    run_cycle(0, 1, 1, 8'h41, 0, 8'h00);
    check("raw_t0_rdy", int'(s_rdy0), 1);
    run_cycle(0, 1, 1, 8'h52, 0, 8'h00);
    check("raw_t1_rdy", int'(s_rdy0), 0);
    run_cycle(0, 1, 1, 8'h52, 0, 8'h00);
    check("raw_t2_rdy", int'(s_rdy0), 0);
    run_cycle(0, 1, 1, 8'h52, 0, 8'h00);
    check("raw_t3_rdy", int'(s_rdy0), 1);
    check("raw_stall", int'(stall_cnt), 2);

    // Blocked priority holder does not hold up an independent requester.
    do_reset();
    run_cycle(0, 1, 0, 8'h00, 1, 8'h41);
    check("bypass_t0_rdy1", int'(s_rdy1), 1);
    run_cycle(0, 1, 1, 8'h52, 1, 8'hEB);
    check("bypass_t1_rdy0", int'(s_rdy0), 0);
    check("bypass_t1_rdy1", int'(s_rdy1), 1);
    check("bypass_t1_inst", int'(s_inst), 8'hEB);

    // Ten cycles of NOPs from both sides alternate evenly.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      run_cycle(0, 1, 1, 8'h00, 1, 8'h00);
      check($sformatf("nop%0d_src", i), int'(s_src), i % 2);
    end
    check("nop_cnt0", int'(issue_cnt0), 5);
    check("nop_cnt1", int'(issue_cnt1), 5);
    check("nop_stall", int'(stall_cnt), 0);

    // Issue disabled while a hazard ages out; reader goes as soon as enabled.
    do_reset();
    run_cycle(0, 1, 1, 8'h41, 0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      run_cycle(0, 0, 1, 8'h52, 0, 8'h00);
      check($sformatf("en_low%0d_rdy", i), int'(s_rdy0), 0);
    end
    check("en_low_stall", int'(stall_cnt), 0);
    run_cycle(0, 1, 1, 8'h52, 0, 8'h00);
    check("en_high_rdy", int'(s_rdy0), 1);

    // Reset right after a writer clears its hazard.
    do_reset();
    run_cycle(0, 1, 1, 8'h43, 0, 8'h00);
    run_cycle(1, 1, 1, 8'h7C, 0, 8'h00);
    check("rst_mid_rdy", int'(s_rdy0), 0);
    check("rst_mid_cnt0", int'(issue_cnt0), 0);
    run_cycle(0, 1, 1, 8'h7C, 0, 8'h00);
    check("rst_after_rdy", int'(s_rdy0), 1);

    // Random traffic; requesters hold each instruction until accepted.
    do_reset();
    hv0 = 0; hv1 = 0; hi0 = 8'h00; hi1 = 8'h00;
    for (int i = 0; i < 1500; i++) begin
      if (!hv0 && $urandom_range(0, 3) != 0) begin hv0 = 1; hi0 = 8'($urandom); end
      if (!hv1 && $urandom_range(0, 3) != 0) begin hv1 = 1; hi1 = 8'($urandom); end
      rr  = ($urandom_range(0, 99) == 0);
      ren = ($urandom_range(0, 7) != 0);
      run_cycle(rr, ren, hv0, hi0, hv1, hi1);
      if (last_g == 0) hv0 = 0;
      if (last_g == 1) hv1 = 0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
